multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Parametrised multi-cycle sequencer that replaces the single-cycle top-level's implicit "everything in one clock" timing. It owns the PC, instruction register, memory-data register and the fetch/decode/execute/memory/writeback state machine, and drives ready/acknowledge handshakes to instruction and data memories so those can have wait states. ControlUnit, registerBank, ALUControl and CPSR_module stay outside; this block sequences them and gates their write enables.

## Interface
- DATA_W, 32, datapath width (instruction, ALU result, memory data)
- ADDR_W, 32, PC and memory address width
- PC_STEP, 1, PC increment per instruction (1 = word-addressed, 4 = byte-addressed)
- RESET_PC, 0, PC value after reset
- CNT_W, 32, perf counter width (only with MCS_PERF_COUNTERS_EN)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- halt  in  1  request stop at next instruction boundary
- imem_req / imem_addr / imem_ack / imem_rdata  out 1 / out ADDR_W / in 1 / in DATA_W  instruction fetch handshake
- dmem_req / dmem_we / dmem_addr / dmem_wdata / dmem_ack / dmem_rdata  out 1 / out 1 / out ADDR_W / out DATA_W / in 1 / in DATA_W  data handshake
- alu_result  in  DATA_W  from ALUControl
- store_value  in  DATA_W  Rh value for stores
- link_value  in  ADDR_W  from registerBank
- cond_pass  in  1  CPSR condition result (write_condition)
- is_mem, mem_read, writes_reg, set_flags, branch, branch_to_link, store_link  in  1 each  decoded controls
- instr  out  DATA_W  instruction register
- pc  out  ADDR_W  current instruction address
- reg_we / reg_wdata  out 1 / out DATA_W  register file write
- link_we  out  1  link register write (value = pc)
- flags_we  out  1  CPSR update strobe
- halted, state  out  1 / out 3  status
- cycle_count, instret_count  out  CNT_W each  (only with MCS_PERF_COUNTERS_EN)

## Operation
- States: FETCH(0), DECODE(1), EXECUTE(2), MEM(3), WRITEBACK(4), HALT(5).
- FETCH: if halt=1 -> HALT, no request. Else imem_req=1, imem_addr=pc; on imem_ack: instr<=imem_rdata, -> DECODE.
- DECODE: one cycle, no strobes; external decode/register read settle.
- EXECUTE: aluout<=alu_result, cond_q<=cond_pass; flags_we=set_flags (single cycle). is_mem & cond_pass -> MEM, else -> WRITEBACK.
- MEM: dmem_req=1, dmem_addr=aluout[ADDR_W-1:0], dmem_we=~mem_read, dmem_wdata=store_value; held stable until dmem_ack. On ack: mdr<=dmem_rdata if mem_read; -> WRITEBACK.
- WRITEBACK (one cycle): reg_we=cond_q & writes_reg & ~(is_mem & ~mem_read); reg_wdata=(is_mem & mem_read) ? mdr : aluout; link_we=cond_q & store_link. PC: cond_q & branch -> (branch_to_link ? link_value : aluout); else pc+PC_STEP (modulo 2^ADDR_W). -> FETCH.
- HALT: no requests; halted=1; leaves to FETCH when halt=0.
- Acks outside the matching request state are ignored.

## Timing
- Reset: state=FETCH, pc=RESET_PC, instr=0, aluout=mdr=0, cond_q=0, all req/we/strobes 0, halted=0, counters 0.
- Zero-wait memories (ack same cycle as req): ALU/branch instruction 4 cycles, memory instruction 5 cycles; each wait cycle adds one.
- Decoded inputs must be stable from DECODE through WRITEBACK (derived from instr, constant).
- Reset mid-handshake: request drops next cycle; pending access abandoned, no register/link/flag write.
- halt asserted mid-instruction: current instruction completes; HALT entered from next FETCH.
- PC wrap: all-ones region + PC_STEP wraps to low addresses, no error.

## Configuration
- MCS_PERF_COUNTERS_EN defined: cycle_count increments every non-reset cycle except in HALT; instret_count increments once per WRITEBACK (condition-failed instructions count); both wrap at 2^CNT_W.
- Undefined: counter ports and logic absent; behaviour otherwise identical.

## Structure
- Shared package core_pkg: state enum and encodings, default widths, PC_STEP default.
- One sub-module natural: mcs_perf_counters (instantiated only under the macro).

## Test plan
- Reset, zero-wait imem returns ADD with cond_pass=1, writes_reg=1, alu_result=0x2A -> reg_we=1, reg_wdata=0x2A in cycle 4, pc 0->1.
- Load, alu_result=0x10, dmem_ack after 2 waits, dmem_rdata=0xDEADBEEF -> dmem_addr=0x10 held 3 cycles, reg_wdata=0xDEADBEEF, total 7 cycles.
- Store with cond_pass=0 -> no MEM state, dmem_req never 1, reg_we=0, pc+1.
- Branch-to-link, link_value=0x40, store_link=1 -> link_we=1, next imem_addr=0x40; PC_STEP=4, pc=0xFFFFFFFC non-branch -> 0x0.
- halt during EXECUTE -> instruction retires, halted=1, no imem_req until halt=0; reset during MEM wait -> FETCH, pc=RESET_PC, no write strobes.
- With MCS_PERF_COUNTERS_EN: three ALU instructions zero-wait -> cycle_count=12, instret_count=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multicycle sequencer: the state encoding and
// the default widths/step used by the sequencer, its bus interface and the
// optional performance counters.
package core_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_PC_STEP  = 1;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_CNT_W    = 32;

  // Encodings are architecturally visible on the 'state' status output.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction and data memory ports of the multicycle sequencer.
//
// Handshake: *_req is the valid, *_ack is the ready. A transfer happens on
// the rising edge where req and ack are both high. While req is high the
// master holds address, write enable and write data stable; the slave may
// keep ack low for any number of wait cycles. Read data is sampled only on
// the transfer edge. An ack while req is low carries no meaning.
interface multicycle_sequencer_if
  import core_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mcs_perf_counters.sv
// Cycle and retired-instruction counters for the multicycle sequencer.
// Only built when MCS_PERF_COUNTERS_EN is defined. Both counters wrap.
`ifdef MCS_PERF_COUNTERS_EN
module mcs_perf_counters
  import core_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_cycle,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Next counter values; modulo arithmetic gives the wrap for free.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (count_cycle) cycle_d = cycle_q + 1'b1;
    if (retire) instret_d = instret_q + 1'b1;
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer: owns PC, instruction register, ALU-output register
// and memory-data register, and steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK so
// instruction and data memories may insert wait states. Decode, register
// file, ALU and CPSR live outside; this block gates their write strobes.
// Optional feature: define MCS_PERF_COUNTERS_EN to add cycle/instret
// counters and their output ports.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
`ifdef MCS_PERF_COUNTERS_EN
  ,
  parameter int              CNT_W    = DEF_CNT_W
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  multicycle_sequencer_if.master mem,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     store_value,
  input  logic [ADDR_W-1:0]     link_value,
  input  logic                  cond_pass,
  input  logic                  is_mem,
  input  logic                  mem_read,
  input  logic                  writes_reg,
  input  logic                  set_flags,
  input  logic                  branch,
  input  logic                  branch_to_link,
  input  logic                  store_link,
  output logic [DATA_W-1:0]     instr,
  output logic [ADDR_W-1:0]     pc,
  output logic                  reg_we,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic                  link_we,
  output logic                  flags_we,
  output logic                  halted,
  output logic [2:0]            state
`ifdef MCS_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instret_count
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              cond_q, cond_d;

  logic              imem_req_c;
  logic              dmem_req_c;
  logic              dmem_we_c;

  // Next-state, register updates and per-state strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    cond_d     = cond_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we     = 1'b0;
    link_we    = 1'b0;
    flags_we   = 1'b0;
    halted     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // halt is only honoured here, so an instruction in flight always retires.
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          imem_req_c = 1'b1;
          if (mem.imem_ack) begin
            instr_d = mem.imem_rdata;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        // Settling cycle for external decode and register read.
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        aluout_d = alu_result;
        cond_d   = cond_pass;
        flags_we = set_flags;
        state_d  = (is_mem && cond_pass) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        // Address comes from the registered ALU output, so it stays stable
        // across wait cycles.
        dmem_req_c = 1'b1;
        dmem_we_c  = ~mem_read;
        if (mem.dmem_ack) begin
          if (mem_read) mdr_d = mem.dmem_rdata;
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        reg_we  = cond_q & writes_reg & ~(is_mem & ~mem_read);
        link_we = cond_q & store_link;
        if (cond_q && branch) begin
          pc_d = branch_to_link ? link_value : ADDR_W'(aluout_q);
        end else begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      cond_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      cond_q   <= cond_d;
    end
  end

  // FETCH is the reset state; keep the fetch request quiet while reset is held.
  assign mem.imem_req   = imem_req_c & ~reset;
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_req   = dmem_req_c;
  assign mem.dmem_we    = dmem_we_c;
  assign mem.dmem_addr  = ADDR_W'(aluout_q);
  assign mem.dmem_wdata = store_value;

  assign instr     = instr_q;
  assign pc        = pc_q;
  assign reg_wdata = (is_mem && mem_read) ? mdr_q : aluout_q;
  assign state     = state_q;

`ifdef MCS_PERF_COUNTERS_EN
  mcs_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clock         (clock),
    .reset         (reset),
    .count_cycle   (state_q != ST_HALT),
    .retire        (state_q == ST_WRITEBACK),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer. Inputs are driven and outputs sampled
// on the falling clock edge. Expected behaviour of each instruction is
// derived from its decoded fields and memory wait counts.
module tb_multicycle_sequencer;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;
  logic [31:0] alu_result, store_value, link_value;
  logic        cond_pass, is_mem, mem_read, writes_reg, set_flags;
  logic        branch, branch_to_link, store_link;
  logic [31:0] instr, pc, reg_wdata;
  logic        reg_we, link_we, flags_we, halted;
  logic [2:0]  state;
  logic [31:0] d4_instr, d4_pc, d4_reg_wdata;
  logic        d4_reg_we, d4_link_we, d4_flags_we, d4_halted;
  logic [2:0]  d4_state;
`ifdef MCS_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count, d4_cycle_count, d4_instret_count;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  int          last_len;

  typedef struct {
    logic [31:0] word, alu, sv, lv, mrdata;
    logic        cond, is_mem, mem_read, writes_reg, set_flags;
    logic        branch, btl, store_link;
    int          iw, dw;
  } instr_t;

  always #5 clock = ~clock;

  multicycle_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
  multicycle_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mem4_if ();

  multicycle_sequencer #(.DATA_W(32), .ADDR_W(32), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .halt(halt), .mem(mem_if),
    .alu_result(alu_result), .store_value(store_value), .link_value(link_value),
    .cond_pass(cond_pass), .is_mem(is_mem), .mem_read(mem_read),
    .writes_reg(writes_reg), .set_flags(set_flags), .branch(branch),
    .branch_to_link(branch_to_link), .store_link(store_link),
    .instr(instr), .pc(pc), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .link_we(link_we), .flags_we(flags_we), .halted(halted), .state(state)
`ifdef MCS_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  // Byte-addressed instance parked at the top of the address space, running
  // back-to-back non-branch ALU instructions from a zero-wait memory.
  multicycle_sequencer #(.DATA_W(32), .ADDR_W(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC)) dut4 (
    .clock(clock), .reset(reset), .halt(1'b0), .mem(mem4_if),
    .alu_result(32'h0), .store_value(32'h0), .link_value(32'h0),
    .cond_pass(1'b1), .is_mem(1'b0), .mem_read(1'b0),
    .writes_reg(1'b1), .set_flags(1'b0), .branch(1'b0),
    .branch_to_link(1'b0), .store_link(1'b0),
    .instr(d4_instr), .pc(d4_pc), .reg_we(d4_reg_we), .reg_wdata(d4_reg_wdata),
    .link_we(d4_link_we), .flags_we(d4_flags_we), .halted(d4_halted), .state(d4_state)
`ifdef MCS_PERF_COUNTERS_EN
    , .cycle_count(d4_cycle_count), .instret_count(d4_instret_count)
`endif
  );

  assign mem4_if.imem_ack   = 1'b1;
  assign mem4_if.imem_rdata = 32'h0000_0001;
  assign mem4_if.dmem_ack   = 1'b1;
  assign mem4_if.dmem_rdata = 32'h0;

  function automatic instr_t blank(input logic [31:0] word);
    instr_t t;
    t.word = word; t.alu = '0; t.sv = '0; t.lv = '0; t.mrdata = '0;
    t.cond = 1'b1; t.is_mem = 1'b0; t.mem_read = 1'b0; t.writes_reg = 1'b0;
    t.set_flags = 1'b0; t.branch = 1'b0; t.btl = 1'b0; t.store_link = 1'b0;
    t.iw = 0; t.dw = 0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.word = $urandom; t.alu = $urandom; t.sv = $urandom; t.lv = $urandom;
    t.mrdata = $urandom;
    t.cond = 1'($urandom); t.is_mem = 1'($urandom); t.mem_read = 1'($urandom);
    t.writes_reg = 1'($urandom); t.set_flags = 1'($urandom);
    t.branch = 1'($urandom); t.btl = 1'($urandom); t.store_link = 1'($urandom);
    t.iw = $urandom_range(0, 3); t.dw = $urandom_range(0, 3);
    return t;
  endfunction

  task automatic drive_ctrl(input instr_t t);
    alu_result = t.alu; store_value = t.sv; link_value = t.lv;
    cond_pass = t.cond; is_mem = t.is_mem; mem_read = t.mem_read;
    writes_reg = t.writes_reg; set_flags = t.set_flags; branch = t.branch;
    branch_to_link = t.btl; store_link = t.store_link;
  endtask

  // Runs one instruction from a FETCH-cycle falling edge to the falling edge
  // of the following FETCH cycle, checking every cycle along the way.
  task automatic run_instr(input instr_t t, input bit halt_in_exec);
    state_e      seq[$];
    logic        mem_taken, e_reg_we, e_link_we;
    logic [31:0] e_wdata, e_next_pc;
    int          fi, mi;
    mem_taken = t.is_mem & t.cond;
    for (int i = 0; i <= t.iw; i++) seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    seq.push_back(ST_EXECUTE);
    if (mem_taken) for (int i = 0; i <= t.dw; i++) seq.push_back(ST_MEM);
    seq.push_back(ST_WRITEBACK);
    e_reg_we  = t.cond & t.writes_reg & ~(t.is_mem & ~t.mem_read);
    e_wdata   = (t.is_mem & t.mem_read) ? t.mrdata : t.alu;
    e_link_we = t.cond & t.store_link;
    e_next_pc = (t.cond & t.branch) ? (t.btl ? t.lv : t.alu) : exp_pc + 32'd1;
    drive_ctrl(t);
    halt = 1'b0;
    fi = 0;
    mi = 0;
    #1;
    foreach (seq[k]) begin
      checks++;
      if (state !== seq[k]) begin
        failures++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", k, state, seq[k]);
      end
      checks++;
      if ((seq[k] != ST_FETCH && mem_if.imem_req !== 1'b0) ||
          (seq[k] != ST_MEM && mem_if.dmem_req !== 1'b0) ||
          (seq[k] != ST_EXECUTE && flags_we !== 1'b0) ||
          (seq[k] != ST_WRITEBACK && (reg_we !== 1'b0 || link_we !== 1'b0)) ||
          halted !== 1'b0) begin
        failures++;
        $display("FAIL idle_strobes cyc=%0d st=%0d got imem_req=%b dmem_req=%b flags_we=%b reg_we=%b link_we=%b halted=%b exp all 0 outside owning state",
                 k, seq[k], mem_if.imem_req, mem_if.dmem_req, flags_we, reg_we, link_we, halted);
      end
      // Junk acks and data outside the owning state must be ignored.
      mem_if.imem_ack   = 1'($urandom);
      mem_if.dmem_ack   = 1'($urandom);
      mem_if.imem_rdata = $urandom;
      mem_if.dmem_rdata = $urandom;
      case (seq[k])
        ST_FETCH: begin
          checks++;
          if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== exp_pc || pc !== exp_pc) begin
            failures++;
            $display("FAIL fetch got req=%b addr=%h pc=%h exp req=1 addr=pc=%h",
                     mem_if.imem_req, mem_if.imem_addr, pc, exp_pc);
          end
          mem_if.imem_ack = (fi == t.iw);
          if (fi == t.iw) mem_if.imem_rdata = t.word;
          fi++;
        end
        ST_DECODE: begin
          checks++;
          if (instr !== t.word) begin
            failures++;
            $display("FAIL instr got=%h exp=%h", instr, t.word);
          end
        end
        ST_EXECUTE: begin
          checks++;
          if (flags_we !== t.set_flags) begin
            failures++;
            $display("FAIL flags_we got=%b exp=%b", flags_we, t.set_flags);
          end
          if (halt_in_exec) halt = 1'b1;
        end
        ST_MEM: begin
          checks++;
          if (mem_if.dmem_req !== 1'b1 || mem_if.dmem_addr !== t.alu ||
              mem_if.dmem_we !== ~t.mem_read || mem_if.dmem_wdata !== t.sv) begin
            failures++;
            $display("FAIL dmem got req=%b addr=%h we=%b wdata=%h exp req=1 addr=%h we=%b wdata=%h",
                     mem_if.dmem_req, mem_if.dmem_addr, mem_if.dmem_we, mem_if.dmem_wdata,
                     t.alu, ~t.mem_read, t.sv);
          end
          mem_if.dmem_ack = (mi == t.dw);
          if (mi == t.dw) mem_if.dmem_rdata = t.mrdata;
          mi++;
        end
        ST_WRITEBACK: begin
          checks++;
          if (reg_we !== e_reg_we || link_we !== e_link_we || instr !== t.word) begin
            failures++;
            $display("FAIL wb_strobes got reg_we=%b link_we=%b instr=%h exp reg_we=%b link_we=%b instr=%h",
                     reg_we, link_we, instr, e_reg_we, e_link_we, t.word);
          end
          if (e_reg_we) begin
            checks++;
            if (reg_wdata !== e_wdata) begin
              failures++;
              $display("FAIL reg_wdata got=%h exp=%h", reg_wdata, e_wdata);
            end
          end
        end
        default: ;
      endcase
      @(negedge clock);
    end
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    exp_pc   = e_next_pc;
    last_len = seq.size();
    #1;
    checks++;
    if (state !== ST_FETCH || pc !== exp_pc) begin
      failures++;
      $display("FAIL retire got state=%0d pc=%h exp state=%0d pc=%h", state, pc, ST_FETCH, exp_pc);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    halt  = 1'b0;
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (state !== ST_FETCH || pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs got state=%0d pc=%h instr=%h exp 0/0/0", state, pc, instr);
    end
    checks++;
    if (mem_if.imem_req !== 1'b0 || mem_if.dmem_req !== 1'b0 || reg_we !== 1'b0 ||
        link_we !== 1'b0 || flags_we !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got imem_req=%b dmem_req=%b reg_we=%b link_we=%b flags_we=%b halted=%b exp all 0",
               mem_if.imem_req, mem_if.dmem_req, reg_we, link_we, flags_we, halted);
    end
`ifdef MCS_PERF_COUNTERS_EN
    checks++;
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters got cyc=%0d ret=%0d exp 0/0", cycle_count, instret_count);
    end
`endif
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    reset  = 1'b0;
    exp_pc = 32'h0;
  endtask

  task automatic test_add();
    instr_t t;
    t = blank(32'hE081_0002);
    t.alu = 32'h2A;
    t.writes_reg = 1'b1;
    run_instr(t, 1'b0);
  endtask

  task automatic test_load_wait();
    instr_t t;
    t = blank(32'hE591_0000);
    t.alu = 32'h10; t.is_mem = 1'b1; t.mem_read = 1'b1; t.writes_reg = 1'b1;
    t.dw = 2; t.mrdata = 32'hDEAD_BEEF;
    run_instr(t, 1'b0);
  endtask

  task automatic test_store_cond_fail();
    instr_t t;
    t = blank(32'h0581_0000);
    t.alu = 32'h20; t.sv = 32'h1234_5678; t.is_mem = 1'b1; t.cond = 1'b0;
    t.store_link = 1'b1;
    run_instr(t, 1'b0);
  endtask

  task automatic test_branch_link();
    instr_t t;
    t = blank(32'hEB00_0010);
    t.alu = 32'h99; t.lv = 32'h40; t.branch = 1'b1; t.btl = 1'b1; t.store_link = 1'b1;
    run_instr(t, 1'b0);
    run_instr(blank(32'hE1A0_0000), 1'b0);
  endtask

  task automatic test_pc_wrap();
    instr_t t;
    t = blank(32'hEA00_0000);
    t.alu = 32'hFFFF_FFFF; t.branch = 1'b1;
    run_instr(t, 1'b0);
    run_instr(blank(32'hE1A0_0000), 1'b0);
    // Byte-addressed instance: 0xFFFFFFFC + 4 wraps to 0, then 4.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 32'h0;
    #1;
    checks++;
    if (d4_pc !== 32'hFFFF_FFFC || d4_state !== ST_FETCH) begin
      failures++;
      $display("FAIL wrap_start got pc=%h state=%0d exp pc=fffffffc state=0", d4_pc, d4_state);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (d4_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc got=%h exp=00000000", d4_pc);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (d4_pc !== 32'h4) begin
      failures++;
      $display("FAIL wrap_next got=%h exp=00000004", d4_pc);
    end
    checks++;
    if (pc !== 32'h0 || state !== ST_FETCH) begin
      failures++;
      $display("FAIL wrap_main_idle got pc=%h state=%0d exp pc=0 state=0", pc, state);
    end
  endtask

  task automatic test_halt();
    instr_t t;
    t = rand_instr();
    run_instr(t, 1'b1);
    checks++;
    if (mem_if.imem_req !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_fetch got imem_req=%b halted=%b exp 0/0", mem_if.imem_req, halted);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (state !== ST_HALT || halted !== 1'b1 || mem_if.imem_req !== 1'b0 || pc !== exp_pc) begin
        failures++;
        $display("FAIL halt_hold got state=%0d halted=%b imem_req=%b pc=%h exp state=5 halted=1 req=0 pc=%h",
                 state, halted, mem_if.imem_req, pc, exp_pc);
      end
      mem_if.imem_ack = 1'b1;
    end
    halt = 1'b0;
    mem_if.imem_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (state !== ST_FETCH || halted !== 1'b0 || mem_if.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL halt_release got state=%0d halted=%b imem_req=%b exp 0/0/1", state, halted, mem_if.imem_req);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) run_instr(rand_instr(), 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    instr_t t;
    t = blank(32'hE591_0000);
    t.alu = 32'h80; t.is_mem = 1'b1; t.mem_read = 1'b1; t.writes_reg = 1'b1;
    t.store_link = 1'b1; t.set_flags = 1'b1;
    drive_ctrl(t);
    mem_if.imem_ack = 1'b1;
    mem_if.imem_rdata = t.word;
    @(negedge clock);
    mem_if.imem_ack = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (state !== ST_MEM || mem_if.dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mem_enter got state=%0d dmem_req=%b exp 3/1", state, mem_if.dmem_req);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (state !== ST_FETCH || mem_if.dmem_req !== 1'b0 || reg_we !== 1'b0 || link_we !== 1'b0 ||
        flags_we !== 1'b0 || mem_if.imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mem got state=%0d dmem_req=%b reg_we=%b link_we=%b flags_we=%b imem_req=%b pc=%h instr=%h exp FETCH, all 0",
               state, mem_if.dmem_req, reg_we, link_we, flags_we, mem_if.imem_req, pc, instr);
    end
    reset  = 1'b0;
    exp_pc = 32'h0;
    run_instr(blank(32'hE1A0_0000), 1'b0);
  endtask

`ifdef MCS_PERF_COUNTERS_EN
  task automatic test_perf();
    instr_t t;
    int     exp_cyc;
    test_reset();
    exp_cyc = 0;
    for (int n = 0; n < 3; n++) begin
      t = rand_instr();
      t.is_mem = 1'b0; t.iw = 0;
      run_instr(t, 1'b0);
      exp_cyc += last_len;
    end
    checks++;
    if (cycle_count !== 32'(exp_cyc) || instret_count !== 32'd3) begin
      failures++;
      $display("FAIL perf got cyc=%0d ret=%0d exp cyc=%0d ret=3", cycle_count, instret_count, exp_cyc);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; halt = 1'b0;
    drive_ctrl(blank(32'h0));
    mem_if.imem_ack = 1'b0; mem_if.imem_rdata = '0;
    mem_if.dmem_ack = 1'b0; mem_if.dmem_rdata = '0;
    exp_pc = '0;
    last_len = 0;
    test_reset();
    test_add();
    test_load_wait();
    test_store_cond_fail();
    test_branch_link();
    test_pc_wrap();
    test_halt();
    test_random();
    test_reset_mid_mem();
`ifdef MCS_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
